// File: rtl/complex_pkg.sv
// ----------------------------------------------------------------------------
// complex_pkg
// Shared constants for the complex frame accumulator:
//   IN_W          - width of the signed real/imag input samples
//   ACC_W_DEFAULT - default accumulator / output width
//   ST_EMPTY/FULL - output holding-register state encoding
// ----------------------------------------------------------------------------
package complex_pkg;

    localparam int IN_W          = 8;
    localparam int ACC_W_DEFAULT = 16;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

endpackage : complex_pkg

// File: rtl/sat_add.sv
// ----------------------------------------------------------------------------
// sat_add
// Signed W-bit adder that clamps to [-2^(W-1), 2^(W-1)-1].
// Ports:
//   a, b  - signed W-bit operands
//   sum   - clamped signed W-bit result
//   sat   - 1 when the exact result was out of range and got clamped
// ----------------------------------------------------------------------------
module sat_add #(
    parameter int W = 16
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic                sat
);

    logic signed [W:0] full_sum;
    logic              ovf;

    // One guard bit: overflow shows up as the top two bits disagreeing.
    assign full_sum = (W+1)'(a) + (W+1)'(b);
    assign ovf      = full_sum[W] ^ full_sum[W-1];

    always_comb begin
        sum = full_sum[W-1:0];
        if (ovf) begin
            // Guard bit carries the true sign of the exact result.
            sum = full_sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

    assign sat = ovf;

endmodule : sat_add

// File: rtl/complex_accum.sv
// ----------------------------------------------------------------------------
// complex_accum
// Sums FRAME_LEN signed complex samples per frame with saturation and hands
// the frame sum to a consumer through a one-deep holding register.
//
// Output handshake: a result is transferred on any rising edge where
// out_valid=1 and out_ready=1. out_valid stays high and out_re/out_im/out_sat
// stay stable until that transfer. The input side never stalls: when a new
// frame completes while a result is held and out_ready=0, the new frame is
// dropped and the sticky overrun flag is set.
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   in_valid          - in_re/in_im carry a sample this cycle
//   in_re, in_im      - signed IN_W-bit sample
//   clr               - synchronous abort of the frame being accumulated
//   out_ready         - consumer accepts the held result
//   out_valid         - held result is valid
//   out_re, out_im    - signed ACC_W-bit frame sum
//   out_sat           - some add in the held frame clamped
//   overrun           - sticky: a completed frame was dropped
//   dbg_state         - output holding-register state (EMPTY/FULL)
// ----------------------------------------------------------------------------
module complex_accum
    import complex_pkg::*;
#(
    parameter int FRAME_LEN = 4,
    parameter int ACC_W     = ACC_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  in_re,
    input  logic signed [IN_W-1:0]  in_im,
    input  logic                    clr,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic signed [ACC_W-1:0] out_re,
    output logic signed [ACC_W-1:0] out_im,
    output logic                    out_sat,
    output logic                    overrun,
    output logic [0:0]              dbg_state
);

    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    // Accumulation state
    logic signed [ACC_W-1:0] acc_re_q, acc_re_d;
    logic signed [ACC_W-1:0] acc_im_q, acc_im_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    sat_q, sat_d;

    // Output holding register
    logic [0:0]              state_q, state_d;
    logic signed [ACC_W-1:0] out_re_q, out_re_d;
    logic signed [ACC_W-1:0] out_im_q, out_im_d;
    logic                    out_sat_q, out_sat_d;
    logic                    overrun_q, overrun_d;

    logic signed [ACC_W-1:0] ext_re, ext_im;
    logic signed [ACC_W-1:0] sum_re, sum_im;
    logic                    sat_re, sat_im;
    logic                    take;
    logic                    complete;
    logic                    frame_sat;

    // Signed size cast sign-extends the sample to the accumulator width.
    assign ext_re = ACC_W'(in_re);
    assign ext_im = ACC_W'(in_im);

    sat_add #(.W(ACC_W)) u_add_re (
        .a   (acc_re_q),
        .b   (ext_re),
        .sum (sum_re),
        .sat (sat_re)
    );

    sat_add #(.W(ACC_W)) u_add_im (
        .a   (acc_im_q),
        .b   (ext_im),
        .sum (sum_im),
        .sat (sat_im)
    );

    // clr wins over in_valid: the sample arriving with clr is discarded.
    assign take      = in_valid & ~clr;
    assign complete  = take && (cnt_q == CNT_LAST);
    assign frame_sat = sat_q | sat_re | sat_im;

    // Accumulator next state
    always_comb begin
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        if (clr || complete) begin
            acc_re_d = '0;
            acc_im_d = '0;
            cnt_d    = '0;
            sat_d    = 1'b0;
        end else if (take) begin
            acc_re_d = sum_re;
            acc_im_d = sum_im;
            cnt_d    = cnt_q + CNT_W'(1);
            sat_d    = frame_sat;
        end
    end

    // Output holding-register next state
    always_comb begin
        state_d   = state_q;
        out_re_d  = out_re_q;
        out_im_d  = out_im_q;
        out_sat_d = out_sat_q;
        overrun_d = overrun_q;
        case (state_q)
            ST_EMPTY: begin
                if (complete) begin
                    state_d   = ST_FULL;
                    out_re_d  = sum_re;
                    out_im_d  = sum_im;
                    out_sat_d = frame_sat;
                end
            end
            default: begin // ST_FULL
                if (complete) begin
                    if (out_ready) begin
                        // Old result leaves as the new one arrives.
                        out_re_d  = sum_re;
                        out_im_d  = sum_im;
                        out_sat_d = frame_sat;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else if (out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_re_q  <= '0;
            acc_im_q  <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            state_q   <= ST_EMPTY;
            out_re_q  <= '0;
            out_im_q  <= '0;
            out_sat_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            acc_re_q  <= acc_re_d;
            acc_im_q  <= acc_im_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            state_q   <= state_d;
            out_re_q  <= out_re_d;
            out_im_q  <= out_im_d;
            out_sat_q <= out_sat_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign out_sat   = out_sat_q;
    assign overrun   = overrun_q;
    assign dbg_state = state_q;

endmodule : complex_accum

// File: tb/tb_complex_accum.sv
module tb_complex_accum;
    import complex_pkg::*;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              in_valid = 1'b0;
    logic signed [7:0] in_re    = '0;
    logic signed [7:0] in_im    = '0;
    logic              clr      = 1'b0;
    logic              out_ready = 1'b0;

    // Default instance (FRAME_LEN=4, ACC_W=16)
    logic               ov16;
    logic signed [15:0] ore16, oim16;
    logic               osat16, orun16;
    logic [0:0]         st16;

    // Narrow instance (FRAME_LEN=4, ACC_W=8), same stimulus
    logic               ov8;
    logic signed [7:0]  ore8, oim8;
    logic               osat8, orun8;
    logic [0:0]         st8;

    int errors = 0;
    int checks = 0;

    complex_accum u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_re     (in_re),
        .in_im     (in_im),
        .clr       (clr),
        .out_ready (out_ready),
        .out_valid (ov16),
        .out_re    (ore16),
        .out_im    (oim16),
        .out_sat   (osat16),
        .overrun   (orun16),
        .dbg_state (st16)
    );

    complex_accum #(.FRAME_LEN(4), .ACC_W(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_re     (in_re),
        .in_im     (in_im),
        .clr       (clr),
        .out_ready (out_ready),
        .out_valid (ov8),
        .out_re    (ore8),
        .out_im    (oim8),
        .out_sat   (osat8),
        .overrun   (orun8),
        .dbg_state (st8)
    );

    // ------------------------------------------------------------------
    // Driver tasks: inputs change 1 time unit after the rising edge, and
    // outputs are sampled there too, well away from the next edge.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [7:0] re, input logic signed [7:0] im);
        in_valid = 1'b1;
        in_re    = re;
        in_im    = im;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        clr       = 1'b0;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        #2;
        checks++; if (ov16 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", ov16); end
        checks++; if (ore16 !== 16'sd0 || oim16 !== 16'sd0) begin errors++; $display("FAIL reset_data: got %0d/%0d want 0/0", ore16, oim16); end
        checks++; if (osat16 !== 1'b0 || orun16 !== 1'b0) begin errors++; $display("FAIL reset_flags: sat=%0b ovr=%0b want 0/0", osat16, orun16); end
        checks++; if (st16 !== ST_EMPTY) begin errors++; $display("FAIL reset_state: got %0b want %0b", st16, ST_EMPTY); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        do_reset();
        send(8'sd22, 8'sd26);
        send(8'sd22, 8'sd26);
        send(8'sd22, 8'sd26);
        checks++; if (ov16 !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %0b want 0", ov16); end
        send(8'sd22, 8'sd26);
        checks++; if (ov16 !== 1'b1 || st16 !== ST_FULL) begin errors++; $display("FAIL basic_valid: got %0b st=%0b want 1/1", ov16, st16); end
        checks++; if (ore16 !== 16'sd88 || oim16 !== 16'sd104) begin errors++; $display("FAIL basic_data: got %0d/%0d want 88/104", ore16, oim16); end
        checks++; if (osat16 !== 1'b0) begin errors++; $display("FAIL basic_sat: got %0b want 0", osat16); end
        out_ready = 1'b1;
        tick();
        checks++; if (ov16 !== 1'b0) begin errors++; $display("FAIL basic_drain: got %0b want 0", ov16); end
        out_ready = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 4; i++) send(8'sd127, -8'sd128);
        checks++; if (ov8 !== 1'b1) begin errors++; $display("FAIL sat8_valid: got %0b want 1", ov8); end
        checks++; if (ore8 !== 8'sd127 || oim8 !== -8'sd128) begin errors++; $display("FAIL sat8_data: got %0d/%0d want 127/-128", ore8, oim8); end
        checks++; if (osat8 !== 1'b1) begin errors++; $display("FAIL sat8_flag: got %0b want 1", osat8); end
        checks++; if (ore16 !== 16'sd508 || oim16 !== -16'sd512 || osat16 !== 1'b0) begin errors++; $display("FAIL sat16_nosat: got %0d/%0d sat=%0b want 508/-512 sat=0", ore16, oim16, osat16); end
        // Next frame in range: saturation flag must not leak into it.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(8'sd1, 8'sd1);
        checks++; if (ore8 !== 8'sd4 || osat8 !== 1'b0) begin errors++; $display("FAIL sat8_clear: got %0d sat=%0b want 4 sat=0", ore8, osat8); end
        out_ready = 1'b0;
    endtask

    task automatic test_overrun();
        do_reset();
        for (int i = 0; i < 4; i++) send(8'sd1, 8'sd1);
        checks++; if (ov16 !== 1'b1 || orun16 !== 1'b0) begin errors++; $display("FAIL ovr_first: valid=%0b ovr=%0b want 1/0", ov16, orun16); end
        for (int i = 0; i < 4; i++) send(8'sd2, 8'sd2);
        checks++; if (ore16 !== 16'sd4 || oim16 !== 16'sd4) begin errors++; $display("FAIL ovr_held: got %0d/%0d want 4/4", ore16, oim16); end
        checks++; if (ov16 !== 1'b1 || orun16 !== 1'b1) begin errors++; $display("FAIL ovr_flag: valid=%0b ovr=%0b want 1/1", ov16, orun16); end
        out_ready = 1'b1;
        tick();
        checks++; if (ov16 !== 1'b0 || orun16 !== 1'b1) begin errors++; $display("FAIL ovr_drain: valid=%0b ovr=%0b want 0/1", ov16, orun16); end
        out_ready = 1'b0;
    endtask

    task automatic test_clr();
        do_reset();
        out_ready = 1'b1;
        send(8'sd5, 8'sd5);
        send(8'sd5, 8'sd5);
        // clr together with a valid sample: the sample is dropped too.
        clr = 1'b1;
        send(8'sd9, 8'sd9);
        clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(8'sd1, -8'sd1);
            if (i < 3) begin
                checks++; if (ov16 !== 1'b0) begin errors++; $display("FAIL clr_early_valid%0d: got %0b want 0", i, ov16); end
                tick();
            end
        end
        checks++; if (ov16 !== 1'b1 || ore16 !== 16'sd4 || oim16 !== -16'sd4) begin errors++; $display("FAIL clr_data: valid=%0b got %0d/%0d want 1 4/-4", ov16, ore16, oim16); end
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 8; i++) send(8'sd1, 8'sd1);
        for (int i = 0; i < 3; i++) send(8'sd1, 8'sd1);
        checks++; if (ov16 !== 1'b1 || orun16 !== 1'b1) begin errors++; $display("FAIL arst_pre: valid=%0b ovr=%0b want 1/1", ov16, orun16); end
        // Assert reset between clock edges; outputs must clear without an edge.
        #2 rst = 1'b1;
        #1;
        checks++; if (ov16 !== 1'b0 || ore16 !== 16'sd0 || oim16 !== 16'sd0 || osat16 !== 1'b0 || orun16 !== 1'b0) begin
            errors++; $display("FAIL arst_clear: valid=%0b %0d/%0d sat=%0b ovr=%0b want all 0", ov16, ore16, oim16, osat16, orun16);
        end
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) send(8'sd3, -8'sd7);
        checks++; if (ov16 !== 1'b0) begin errors++; $display("FAIL arst_partial: got %0b want 0", ov16); end
        send(8'sd3, -8'sd7);
        checks++; if (ov16 !== 1'b1 || ore16 !== 16'sd12 || oim16 !== -16'sd28) begin errors++; $display("FAIL arst_data: valid=%0b got %0d/%0d want 1 12/-28", ov16, ore16, oim16); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) send(8'sd1, 8'sd2);
        for (int i = 0; i < 3; i++) send(8'sd3, 8'sd4);
        checks++; if (ore16 !== 16'sd4 || oim16 !== 16'sd8) begin errors++; $display("FAIL b2b_first: got %0d/%0d want 4/8", ore16, oim16); end
        out_ready = 1'b1;
        send(8'sd3, 8'sd4);
        checks++; if (ov16 !== 1'b1 || ore16 !== 16'sd12 || oim16 !== 16'sd16) begin errors++; $display("FAIL b2b_load: valid=%0b got %0d/%0d want 1 12/16", ov16, ore16, oim16); end
        checks++; if (orun16 !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %0b want 0", orun16); end
        tick();
        checks++; if (ov16 !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %0b want 0", ov16); end
        out_ready = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Sequencer and final report
    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_overrun();
        test_clr();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_complex_accum

// File: doc/complex_accum.md
COMPLEX_ACCUM -- requirements
Module: complex_accum

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter FRAME_LEN, default 4: number of complex samples summed per frame, legal range 2..256.
REQ-003 Parameter ACC_W, default 16: signed accumulator and output width, legal range 8..32.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  in_re/in_im carry a product this cycle.
REQ-007 in_re  input  8  signed real part from the upstream complex multiplier.
REQ-008 in_im  input  8  signed imaginary part from the upstream complex multiplier.
REQ-009 clr  input  1  synchronous abort of the frame in progress.
REQ-010 out_ready  input  1  consumer accepts the held result.
REQ-011 out_valid  output  1  held result is valid.
REQ-012 out_re  output  ACC_W  signed frame sum, real part.
REQ-013 out_im  output  ACC_W  signed frame sum, imaginary part.
REQ-014 out_sat  output  1  saturation occurred in either component of the held frame.
REQ-015 overrun  output  1  sticky flag: a completed frame was dropped.

Function
REQ-016 Inputs SHALL be sign-extended to ACC_W before addition; each add SHALL saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
REQ-017 A cycle with in_valid=1 and clr=0 SHALL add in_re/in_im to acc_re/acc_im and increment sample count cnt.
REQ-018 Cycles with in_valid=0 SHALL leave acc and cnt unchanged; bubbles are allowed anywhere in a frame.
REQ-019 A sat bit SHALL be set when any add in the current frame clamps; it clears at frame start.
REQ-020 The sample with cnt==FRAME_LEN-1 completes the frame. On the next edge: final sums -> out_re/out_im, frame sat -> out_sat, out_valid=1, acc=0, cnt=0, sat=0.
REQ-021 Latency SHALL be 1 cycle: out_valid rises on the edge that captures the last sample.
REQ-022 Accumulation SHALL continue into the next frame while a result is held (double-buffered); there is no input stall.
REQ-023 The output state machine SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-024 EMPTY -> FULL on frame completion.
REQ-025 FULL -> EMPTY on out_ready=1 with no completion in the same cycle.
REQ-026 FULL + out_ready=1 + completion in the same cycle: load the new result, stay FULL, overrun unchanged.
REQ-027 FULL + out_ready=0 + completion: discard the new frame, keep the held result, set overrun; acc/cnt still reset.
REQ-028 out_re/out_im/out_sat SHALL remain stable while FULL until the handshake completes.
REQ-029 clr=1 SHALL zero acc, cnt and sat and discard in_valid that cycle; it SHALL NOT affect the output state, output data or overrun.
REQ-030 overrun SHALL clear only on rst.

Reset
REQ-031 On rst, independent of clk: acc_re=0, acc_im=0, cnt=0, sat=0, state=EMPTY, out_valid=0, out_re=0, out_im=0, out_sat=0, overrun=0.
REQ-032 Reset mid-frame SHALL discard the partial frame; the first in_valid after release is sample 0.

Structure
REQ-033 Package complex_pkg SHALL hold IN_W=8, the default ACC_W, and the EMPTY/FULL state encoding.
REQ-034 Saturating addition SHALL be implemented in sub-module sat_add (params W; inputs a, b; outputs sum, sat), instantiated once each for re and im.
REQ-035 cnt width SHALL be clog2(FRAME_LEN).

Verification
REQ-036 Defaults; 4 consecutive valids of (22, 26) -> out_valid=1 one cycle after the 4th, out_re=88, out_im=104, out_sat=0.
REQ-037 ACC_W=8, FRAME_LEN=4; 4 samples of (127, -128) -> out_re=127, out_im=-128, out_sat=1.
REQ-038 Defaults; out_ready held 0 through two full frames (1,1)x4 then (2,2)x4 -> held result stays 4/4, overrun=1; out_ready=1 -> out_valid=0 next cycle.
REQ-039 Defaults; 2 samples (5,5), clr, then 4 samples (1,-1) with bubbles between -> out_re=4, out_im=-4.
REQ-040 Defaults; 3 samples, assert rst mid-cycle -> all outputs 0 immediately; after release, 4 samples (3,-7) -> out_re=12, out_im=-28.
REQ-041 Defaults; FULL, out_ready=1 in the same cycle as the next completion -> new sums loaded, out_valid stays 1, overrun=0.
